// File: rtl/piso_pkg.sv
// Shared constants and FSM state type for the AES-block-to-PISO feeder.
// Optional bit counter output is enabled with PISO_FEEDER_BITCNT_EN.
package piso_pkg;

  localparam int AES_DW_DEF     = 128;
  localparam int FIFO_DEPTH_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_feeder_if.sv
// Block-in / PISO-control bundle between the feeder and its neighbours.
// bits_sent_o exists only when PISO_FEEDER_BITCNT_EN is defined.
interface piso_feeder_if
  import piso_pkg::*;
#(
  parameter int W = AES_DW_DEF
);

  logic         blk_valid_i;
  logic [W-1:0] blk_data_i;
  logic         blk_ready_o;
  logic [W-1:0] piso_data_o;
  logic         piso_load_o;
  logic         piso_en_o;
  logic         sink_ready_i;
  logic         bit_valid_o;
  logic         blk_done_o;
  logic         busy_o;
`ifdef PISO_FEEDER_BITCNT_EN
  logic [31:0]  bits_sent_o;
`endif

  modport slave (
    input  blk_valid_i, blk_data_i, sink_ready_i,
    output blk_ready_o, piso_data_o, piso_load_o,
    output piso_en_o, bit_valid_o, blk_done_o, busy_o
`ifdef PISO_FEEDER_BITCNT_EN
    , output bits_sent_o
`endif
  );

  modport master (
    output blk_valid_i, blk_data_i, sink_ready_i,
    input  blk_ready_o, piso_data_o, piso_load_o,
    input  piso_en_o, bit_valid_o, blk_done_o, busy_o
`ifdef PISO_FEEDER_BITCNT_EN
    , input bits_sent_o
`endif
  );

endinterface

// File: rtl/piso_feeder_fifo.sv
// Block FIFO: power-of-two depth, pointers wrap naturally.
// Push is refused when full even if a pop happens in the same cycle.
module piso_feeder_fifo
  import piso_pkg::*;
#(
  parameter int W     = AES_DW_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = cw(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q + AW'(push_ok);
    rd_d  = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + (AW+1)'(push_ok)
                  - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/piso_feeder.sv
// Feeds buffered AES blocks into an external PISO, LSB first, one bit per sink handshake.
// Define PISO_FEEDER_BITCNT_EN to add the saturating bits_sent_o counter.
module piso_feeder
  import piso_pkg::*;
#(
  parameter int AES_DATA_WIDTH = AES_DW_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  piso_feeder_if.slave  bus
);

  localparam int CW = cw(AES_DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(AES_DATA_WIDTH - 1);

  state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic    full, empty;
  logic    load, en, vld, done;
  logic [AES_DATA_WIDTH-1:0] head;

  piso_feeder_fifo #(
    .W     (AES_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (bus.blk_valid_i),
    .din_i   (bus.blk_data_i),
    .pop_i   (load),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    en      = 1'b0;
    vld     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        vld = 1'b1;
        if (bus.sink_ready_i) begin
          if (cnt_q != LAST) begin
            en    = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end else begin
            done = 1'b1;
            // reload on the last bit keeps the stream bubble-free
            if (!empty) begin
              load  = 1'b1;
              cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.blk_ready_o = ~full;
  assign bus.piso_data_o = head;
  assign bus.piso_load_o = load;
  assign bus.piso_en_o   = en;
  assign bus.bit_valid_o = vld;
  assign bus.blk_done_o  = done;
  assign bus.busy_o      = ~empty | (state_q != IDLE);

`ifdef PISO_FEEDER_BITCNT_EN
  logic [31:0] bits_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits_q <= '0;
    end else if (vld && bus.sink_ready_i && !(&bits_q)) begin
      bits_q <= bits_q + 32'd1;
    end
  end

  assign bus.bits_sent_o = bits_q;
`endif

endmodule

// File: tb/tb_piso_feeder.sv
// Bench for piso_feeder: models the downstream PISO and checks the delivered
// bit stream block by block against the queue of accepted blocks.
module tb_piso_feeder;

  localparam int W = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_feeder_if #(.W(W)) bus();

  piso_feeder #(
    .AES_DATA_WIDTH (W),
    .FIFO_DEPTH     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // downstream PISO: load word, shift right, LSB is the output bit
  logic [W-1:0] sr;
  always @(posedge clk or negedge rst) begin
    if (!rst) sr <= '0;
    else if (bus.piso_load_o) sr <= bus.piso_data_o;
    else if (bus.piso_en_o) sr <= sr >> 1;
  end

  // sink pattern: 0 always ready, 1 toggle, 2 stalled, 3 random
  int mode = 0;
  always @(posedge clk) begin
    #1;
    case (mode)
      0: bus.sink_ready_i = 1'b1;
      1: bus.sink_ready_i = ~bus.sink_ready_i;
      2: bus.sink_ready_i = 1'b0;
      default: bus.sink_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] acc;
  int bitidx = 0;
  int load_cnt, en_cnt, done_cnt, seam_cnt;
  int valid_cnt, run, max_run;
  int overlap_err, en_err, done_err;

  always @(negedge clk) begin
    if (!rst) begin
      bitidx = 0;
      exp_q.delete();
    end else begin
      if (bus.blk_valid_i && bus.blk_ready_o)
        exp_q.push_back(bus.blk_data_i);
      if (bus.piso_load_o && bus.piso_en_o) overlap_err++;
      if (bus.piso_en_o && !(bus.bit_valid_o && bus.sink_ready_i))
        en_err++;
      if (bus.piso_load_o) load_cnt++;
      if (bus.piso_en_o) en_cnt++;
      if (bus.blk_done_o) done_cnt++;
      if (bus.piso_load_o && bus.blk_done_o) seam_cnt++;
      if (bus.bit_valid_o) begin
        valid_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (bus.bit_valid_o && bus.sink_ready_i) begin
        acc[bitidx] = sr[0];
        if (bus.blk_done_o != (bitidx == W-1)) done_err++;
        if (bitidx == W-1) begin
          got_q.push_back(acc);
          bitidx = 0;
        end else begin
          bitidx++;
        end
      end else if (bus.blk_done_o) begin
        done_err++;
      end
    end
  end

  task automatic clr_stats();
    load_cnt = 0; en_cnt = 0; done_cnt = 0; seam_cnt = 0;
    valid_cnt = 0; run = 0; max_run = 0;
    overlap_err = 0; en_err = 0; done_err = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic push_blk(input logic [W-1:0] d, input int budget,
                          output bit ok);
    bus.blk_valid_i = 1'b1;
    bus.blk_data_i  = d;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = bus.blk_ready_o;
      @(posedge clk); #1;
    end
    bus.blk_valid_i = 1'b0;
  endtask

  task automatic wait_blocks(input int n, input int budget,
                             output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      ok = (got_q.size() >= n);
    end
  endtask

  function automatic logic [W-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    #2 rst = 1'b0;
    #2;
    checks++;
    if (bus.blk_ready_o !== 1'b1) begin
      failures++; $display("FAIL rst_ready got=%b exp=1", bus.blk_ready_o);
    end
    checks++;
    if ({bus.piso_load_o, bus.piso_en_o, bus.bit_valid_o} !== 3'b000) begin
      failures++;
      $display("FAIL rst_ctrl got=%b exp=000",
               {bus.piso_load_o, bus.piso_en_o, bus.bit_valid_o});
    end
    checks++;
    if ({bus.blk_done_o, bus.busy_o} !== 2'b00) begin
      failures++;
      $display("FAIL rst_done_busy got=%b exp=00", {bus.blk_done_o, bus.busy_o});
    end
`ifdef PISO_FEEDER_BITCNT_EN
    checks++;
    if (bus.bits_sent_o !== 32'd0) begin
      failures++; $display("FAIL rst_bits got=%0d exp=0", bus.bits_sent_o);
    end
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    mode = 0;
    @(posedge clk); #1;
    clr_stats();
    push_blk(128'h5, 10, ok);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy_o, bus.bit_valid_o} !== 2'b11) begin
      failures++;
      $display("FAIL single_busy got=%b exp=11", {bus.busy_o, bus.bit_valid_o});
    end
    wait_blocks(1, 400, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL single_timeout got=%0d exp=1", got_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ok && got_q[0] !== 128'h5) begin
      failures++; $display("FAIL single_bits got=%h exp=%h", got_q[0], 128'h5);
    end
    checks++;
    if (en_cnt != 127 || load_cnt != 1 || done_cnt != 1) begin
      failures++;
      $display("FAIL single_pulses got=en%0d/ld%0d/dn%0d exp=127/1/1",
               en_cnt, load_cnt, done_cnt);
    end
    checks++;
    if (valid_cnt != W) begin
      failures++; $display("FAIL single_valid got=%0d exp=%0d", valid_cnt, W);
    end
    checks++;
    if ({bus.busy_o, bus.bit_valid_o} !== 2'b00 || done_err != 0) begin
      failures++;
      $display("FAIL single_idle got=%b/%0d exp=00/0",
               {bus.busy_o, bus.bit_valid_o}, done_err);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, ok2;
    mode = 0;
    clr_stats();
    push_blk(rnd_blk(), 10, ok);
    push_blk(rnd_blk(), 10, ok2);
    wait_blocks(2, 800, ok);
    checks++;
    if (!(ok && ok2)) begin
      failures++; $display("FAIL b2b_timeout got=%0d exp=2", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_blk%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (max_run != 2*W || seam_cnt != 1) begin
      failures++;
      $display("FAIL b2b_seam got=run%0d/seam%0d exp=%0d/1",
               max_run, seam_cnt, 2*W);
    end
    checks++;
    if (done_cnt != 2 || overlap_err != 0 || done_err != 0) begin
      failures++;
      $display("FAIL b2b_ctrl got=dn%0d/ov%0d/de%0d exp=2/0/0",
               done_cnt, overlap_err, done_err);
    end
  endtask

  task automatic test_toggle();
    bit ok;
    mode = 1;
    repeat (3) @(posedge clk);
    #1;
    clr_stats();
    push_blk(rnd_blk(), 10, ok);
    wait_blocks(1, 700, ok);
    checks++;
    if (!ok || got_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL toggle_bits got=%h exp=%h", got_q[0], exp_q[0]);
    end
    checks++;
    if (en_err != 0 || en_cnt != W-1) begin
      failures++;
      $display("FAIL toggle_en got=err%0d/en%0d exp=0/%0d", en_err, en_cnt, W-1);
    end
    checks++;
    if (valid_cnt < 2*W-1 || valid_cnt > 2*W) begin
      failures++;
      $display("FAIL toggle_cycles got=%0d exp=%0d", valid_cnt, 2*W);
    end
    mode = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_full();
    bit a, b, c, d;
    logic [W-1:0] blk_d;
    mode = 2;
    repeat (2) @(posedge clk);
    #1;
    clr_stats();
    blk_d = rnd_blk();
    push_blk(rnd_blk(), 5, a);
    push_blk(rnd_blk(), 5, b);
    push_blk(rnd_blk(), 5, c);
    checks++;
    if (!(a && b && c)) begin
      failures++; $display("FAIL full_accept3 got=%b%b%b exp=111", a, b, c);
    end
    push_blk(blk_d, 10, d);
    checks++;
    if (d || bus.blk_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL full_refuse got=%b/%b exp=0/0", d, bus.blk_ready_o);
    end
    checks++;
    if (en_cnt != 0 || bus.bit_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL full_stall got=%0d/%b exp=0/1", en_cnt, bus.bit_valid_o);
    end
    mode = 0;
    push_blk(blk_d, 400, d);
    checks++;
    if (!d) begin
      failures++; $display("FAIL full_late_push got=0 exp=1");
    end
    wait_blocks(4, 1200, d);
    checks++;
    if (!d) begin
      failures++; $display("FAIL full_timeout got=%0d exp=4", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL full_blk%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [W-1:0] blk_c;
    mode = 0;
    clr_stats();
    push_blk(rnd_blk(), 10, ok);
    push_blk(rnd_blk(), 10, ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      ok = (en_cnt == 60);
      if (!ok) begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rmid_reach60 got=%0d exp=60", en_cnt);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({bus.piso_load_o, bus.piso_en_o, bus.bit_valid_o,
         bus.blk_done_o, bus.busy_o, bus.blk_ready_o} !== 6'b000001) begin
      failures++;
      $display("FAIL rmid_async got=%b exp=000001",
               {bus.piso_load_o, bus.piso_en_o, bus.bit_valid_o,
                bus.blk_done_o, bus.busy_o, bus.blk_ready_o});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0 || got_q.size() != 0 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL rmid_discard got=dn%0d/blk%0d/busy%b exp=0/0/0",
               done_cnt, got_q.size(), bus.busy_o);
    end
    blk_c = rnd_blk();
    push_blk(blk_c, 10, ok);
    wait_blocks(1, 400, ok);
    checks++;
    if (!ok || got_q[0] !== blk_c) begin
      failures++; $display("FAIL rmid_restart got=%h exp=%h", got_q[0], blk_c);
    end
    checks++;
    if (en_cnt != 60 + W-1 || done_cnt != 1) begin
      failures++;
      $display("FAIL rmid_cnt got=en%0d/dn%0d exp=%0d/1",
               en_cnt, done_cnt, 60 + W-1);
    end
  endtask

`ifdef PISO_FEEDER_BITCNT_EN
  task automatic test_bitcnt();
    bit ok;
    mode = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    clr_stats();
    push_blk(rnd_blk(), 10, ok);
    push_blk(rnd_blk(), 10, ok);
    wait_blocks(2, 800, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.bits_sent_o !== 32'd256) begin
      failures++; $display("FAIL bitcnt got=%0d exp=256", bus.bits_sent_o);
    end
  endtask
`endif

  task automatic test_random();
    bit ok;
    int n;
    mode = 3;
    clr_stats();
    n = 0;
    for (int k = 0; k < 6; k++) begin
      push_blk(rnd_blk(), 2000, ok);
      if (ok) n++;
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end
    wait_blocks(6, 4000, ok);
    checks++;
    if (!ok || n != 6) begin
      failures++;
      $display("FAIL rand_timeout got=%0d/%0d exp=6/6", n, got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rand_blk%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 6 || done_err != 0 || overlap_err != 0 || en_err != 0) begin
      failures++;
      $display("FAIL rand_ctrl got=dn%0d/de%0d/ov%0d/ee%0d exp=6/0/0/0",
               done_cnt, done_err, overlap_err, en_err);
    end
    mode = 0;
  endtask

  initial begin
    bus.blk_valid_i  = 1'b0;
    bus.blk_data_i   = '0;
    bus.sink_ready_i = 1'b0;
    clr_stats();
    test_reset();
    test_single();
    test_back_to_back();
    test_toggle();
    test_full();
    test_reset_mid();
`ifdef PISO_FEEDER_BITCNT_EN
    test_bitcnt();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_feeder.md
PISO_FEEDER -- requirements
Module: piso_feeder

Interface
REQ-001 SHALL have parameter AES_DATA_WIDTH, default 128, width of one AES block and of the downstream piso load word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, number of buffered blocks; power of two, >=2.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port blk_valid_i  input  1  upstream AES block valid.
REQ-006 SHALL have port blk_data_i  input  AES_DATA_WIDTH  upstream AES block.
REQ-007 SHALL have port blk_ready_o  output  1  block accepted when blk_valid_i&blk_ready_o.
REQ-008 SHALL have port piso_data_o  output  AES_DATA_WIDTH  word driven to piso data_i.
REQ-009 SHALL have port piso_load_o  output  1  drives piso load.
REQ-010 SHALL have port piso_en_o  output  1  drives piso en (shift right).
REQ-011 SHALL have port sink_ready_i  input  1  consumer of piso data_o takes the current bit this cycle.
REQ-012 SHALL have port bit_valid_o  output  1  piso data_o holds a valid bit this cycle.
REQ-013 SHALL have port blk_done_o  output  1  one-cycle pulse when last bit of a block is consumed.
REQ-014 SHALL have port busy_o  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-015 SHALL buffer blocks in a FIFO_DEPTH-entry FIFO; blk_ready_o = !full, no same-cycle bypass when full.
REQ-016 SHALL allow push and pop in one cycle when not full; occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-017 SHALL drive piso_data_o combinationally from FIFO head; piso_load_o asserted pops the head at that edge.
REQ-018 SHALL implement FSM states IDLE and SHIFT plus bit counter cnt, width clog2(AES_DATA_WIDTH).
REQ-019 IDLE: if FIFO non-empty, piso_load_o=1, pop, cnt<=0, go SHIFT; else outputs low, stay.
REQ-020 SHIFT: bit_valid_o=1; if sink_ready_i=0, load/en low, hold state and cnt.
REQ-021 SHIFT, sink_ready_i=1, cnt<AES_DATA_WIDTH-1: piso_en_o=1, cnt<=cnt+1.
REQ-022 SHIFT, sink_ready_i=1, cnt=AES_DATA_WIDTH-1: blk_done_o=1; if FIFO non-empty, piso_load_o=1, pop, cnt<=0, stay SHIFT (zero-bubble); else go IDLE.
REQ-023 SHALL never assert piso_load_o and piso_en_o in the same cycle.
REQ-024 SHALL deliver bits LSB first, one per sink_ready_i handshake, exactly AES_DATA_WIDTH per block.
REQ-025 Sustained throughput SHALL be one bit per cycle; first bit valid one cycle after the load edge.

Reset
REQ-026 rst low SHALL immediately clear FSM to IDLE, cnt, FIFO pointers and occupancy; all outputs 0 except blk_ready_o=1 (piso_data_o = head entry, don't-care).
REQ-027 Reset mid-block SHALL discard partial and buffered blocks; no blk_done_o for them; same rst resets piso.

Configuration
REQ-028 Macro PISO_FEEDER_BITCNT_EN defined: SHALL add output bits_sent_o[31:0], incremented per consumed bit, saturating at 32'hFFFFFFFF, cleared by reset.
REQ-029 Macro undefined: port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package piso_pkg SHALL hold AES_DATA_WIDTH default constant and the FSM state typedef.
REQ-031 FIFO SHALL be sub-module piso_feeder_fifo (storage, pointers, full/empty); FSM and counter in piso_feeder.

Verification
REQ-032 One block 128'h0000_..._0005, sink_ready_i=1 -> load pulse, then bits 1,0,1,0,... over 128 cycles, 127 en pulses, blk_done_o at bit 128.
REQ-033 Two blocks back-to-back, sink always ready -> 256 consecutive bit_valid_o cycles, second load coincides with blk_done_o, no bubble.
REQ-034 sink_ready_i toggling 1,0 -> en only on ready cycles, bit held when not ready, 256 cycles per block.
REQ-035 Push 3 blocks with sink stalled, FIFO_DEPTH=2 -> blk_ready_o=0 after entries fill (head popped to piso frees one), third accepted only after pop.
REQ-036 rst low at cnt=60 -> outputs cleared asynchronously, blk_done_o never pulses, next block restarts at cnt 0.
REQ-037 With PISO_FEEDER_BITCNT_EN, two full blocks -> bits_sent_o=256.
